data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the pipelined CPU's MEM stage: the memory-side end of the load/store interface. It accepts one word request at a time from the EXMEM side, models a fixed multi-cycle access latency, and holds `stall_o` so the pipeline freezes until completion. It returns read data, or commits write data, with a one-cycle `ack_o` pulse. It replaces the zero-latency data memory wherever realistic memory timing must be exercised.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `LATENCY`, 4: wait cycles per access; legal range 1..15.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `req_i`  in  1  access request; the pipeline holds it and all request fields stable while `stall_o`=1.
- `we_i`  in  1  1 = store word, 0 = load word.
- `addr_i`  in  32  byte address.
- `wdata_i`  in  32  store data.
- `stall_o`  out  1  freezes PC, IFID, IDEX and EXMEM while an access is outstanding.
- `ack_o`  out  1  one-cycle completion pulse.
- `rdata_o`  out  32  load result; valid when `ack_o`=1; held until the next load completes.
- `err_o`  out  1  qualifies `ack_o`; 1 = misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, DONE (4-bit latency counter `cnt`).
- IDLE:
  - If `req_i`=1, latch `addr_i`, `we_i` and `wdata_i`; set `cnt`=LATENCY-1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0, perform the access from the latched fields and go to DONE.
  - Inputs are ignored in this state; only latched values are used.
- Access rules:
  - Word index = `addr[$clog2(DEPTH)+1:2]`.
  - Illegal if `addr[1:0]`≠0 or `addr[31:$clog2(DEPTH)+2]`≠0. An illegal store is dropped. An illegal load returns 0. `err_o` is set for both.
  - A legal store writes the array. A legal load registers the array word into `rdata_o`.
- DONE: `ack_o`=1 and `err_o` valid for this one cycle; unconditionally return to IDLE. A `req_i` seen in DONE is not accepted; it is sampled again in IDLE on the next cycle.
- `stall_o` = (IDLE && `req_i`) || WAIT. It is combinational from `req_i` in IDLE only and is 0 in DONE, so the pipeline advances past the completed instruction exactly once.
- Reset (asynchronous, any state):
  - FSM returns to IDLE and `cnt`=0.
  - Outputs go to `stall_o`=0, `ack_o`=0, `err_o`=0, `rdata_o`=0.
  - A pending store is discarded.
  - Memory array contents are not cleared.

## Timing
- A request accepted on edge T completes with `ack_o` high during cycle T+LATENCY+1 (LATENCY WAIT cycles, then DONE).
- A store becomes visible to the next access at that same edge.
- Back-to-back requests: at most one acceptance per LATENCY+2 cycles (IDLE, LATENCY×WAIT, DONE).
- `rdata_o` and `err_o` change only at the edge entering DONE. `err_o` returns to 0 on leaving DONE.
- `req_i` deasserted in IDLE: no state change and `stall_o`=0.

## Structure
- Shared package `dmem_pkg`:
  - State enum `dmem_state_t` {IDLE, WAIT, DONE}.
  - Constants `WORD_W`=32 and `LAT_W`=4.
  - Function `dmem_addr_ok(addr, depth)`.
- One sub-module `dmem_array`: single-port synchronous word RAM (`clk_i`, `we`, `idx`, `wdata`, `rdata`), no reset. The responder owns the FSM, the counter, the latches and the error check.

## Test plan
- Reset at t=0, then `req_i`=1, `we_i`=1, `addr_i`=0x10, `wdata_i`=0xDEADBEEF with LATENCY=4 → `stall_o`=1 for 5 cycles, `ack_o` in the 6th cycle, `err_o`=0.
- Load from 0x10 after that store → `ack_o` after 5 stalled cycles, `rdata_o`=0xDEADBEEF, held through later idle cycles.
- Store to 0x13 → `err_o`=1 with `ack_o`; a subsequent load from 0x10 still returns 0xDEADBEEF.
- Load from 0x1000 (DEPTH=1024) → `err_o`=1, `rdata_o`=0.
- `req_i` held high continuously for two loads → acceptances exactly 6 cycles apart; `ack_o` never high for 2 consecutive cycles.
- `rst_i` low during WAIT of a store to 0x20 (value 0x55) → immediate IDLE with `stall_o`=0; a subsequent load from 0x20 returns its pre-store value.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types, constants and the address legality check for the data-memory responder.
package dmem_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  // A word access is legal when it is word aligned and falls inside a
  // memory of 'depth' words (depth is a power of two).
  function automatic logic dmem_addr_ok(input logic [WORD_W-1:0] addr,
                                        input int unsigned       depth);
    logic [WORD_W:0] limit;
    limit = (WORD_W + 1)'(depth) << 2;
    return (addr[1:0] == 2'b00) && ({1'b0, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; read returns the old word on a same-cycle write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Write on request, registered read of the addressed word every cycle.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    rdata <= mem[idx];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one word request, waits LATENCY cycles,
// then acks with read data or a committed store while holding the pipeline.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic              stall_o,
  output logic              ack_o,
  output logic [WORD_W-1:0] rdata_o,
  output logic              err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  dmem_state_t       state_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              we_q;
  logic              ack_q;
  logic              err_q;
  logic [WORD_W-1:0] rdata_q;

  logic              addr_ok;
  logic              access_now;
  logic              ram_we;
  logic [IDX_W-1:0]  ram_idx;
  logic [WORD_W-1:0] ram_rdata;

  // Legality and RAM controls derived from the latched request. In IDLE the
  // RAM is pointed at the incoming address so its registered read is ready
  // even when there is only a single wait cycle.
  always_comb begin
    addr_ok    = dmem_addr_ok(addr_q, DEPTH);
    access_now = (state_q == WAIT) && (cnt_q == '0);
    ram_we     = access_now && we_q && addr_ok;
    ram_idx    = (state_q == IDLE) ? addr_i[IDX_W+1:2] : addr_q[IDX_W+1:2];
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i (clk_i),
    .we    (ram_we),
    .idx   (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Request FSM with latency counter, request latches and registered results.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            we_q    <= we_i;
            cnt_q   <= LAT_W'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
          end else begin
            ack_q   <= 1'b1;
            err_q   <= ~addr_ok;
            state_q <= DONE;
            if (!we_q) begin
              rdata_q <= addr_ok ? ram_rdata : '0;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational from req_i only while idle; forced low in reset.
  always_comb begin
    stall_o = rst_i && (((state_q == IDLE) && req_i) || (state_q == WAIT));
  end

  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expectations are queued at request
// time from a bench-side memory model and popped on every ack.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 4;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int          n_assert = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rdata = '0;
  logic        prev_ack = 1'b0;

  data_mem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (req_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .stall_o (stall_o),
    .ack_o   (ack_o),
    .rdata_o (rdata_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compute the expected completion of one access and update the model.
  task automatic push_expect(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    logic legal;
    legal = (a[1:0] == 2'b00) && (a < DEPTH * 4);
    e.err = ~legal;
    if (w) begin
      if (legal) model_mem[a[11:2]] = d;
      e.rdata = last_rdata;
    end else begin
      e.rdata = legal ? model_mem[a[11:2]] : 32'h0;
      last_rdata = e.rdata;
    end
    sb_q.push_back(e);
  endtask

  // Single access with stall/ack timing checks.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d);
    int   n_stall;
    logic got;
    push_expect(w, a, d);
    @(negedge clk_i);
    req_i = 1'b1; we_i = w; addr_i = a; wdata_i = d;
    n_stall = 0;
    got = 1'b0;
    #1;
    if (stall_o) n_stall++;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk_i);
      if (ack_o) begin
        got = 1'b1;
        check_eq("stall_in_done", {31'b0, stall_o}, 32'd0);
      end else if (stall_o) begin
        n_stall++;
      end
    end
    req_i = 1'b0;
    check_eq("ack_seen", {31'b0, got}, 32'd1);
    check_eq("stall_cycles", n_stall, LAT + 1);
  endtask

  // Scoreboard side: compare every completion against the oldest expectation.
  always @(negedge clk_i) begin
    if (ack_o) begin
      check_eq("ack_not_back_to_back", {31'b0, prev_ack}, 32'd0);
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ack", {31'b0, ack_o}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("err", {31'b0, err_o}, {31'b0, e.err});
        check_eq("rdata", rdata_o, e.rdata);
      end
    end
    prev_ack = ack_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          t_ack[2];
    int          k;
    int          c;
    // Reset state
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
    check_eq("rst_ack", {31'b0, ack_o}, 32'd0);
    check_eq("rst_err", {31'b0, err_o}, 32'd0);
    check_eq("rst_rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Idle with no request
    repeat (2) @(negedge clk_i);
    check_eq("idle_stall", {31'b0, stall_o}, 32'd0);
    check_eq("idle_ack", {31'b0, ack_o}, 32'd0);

    // Store then load back, rdata held afterwards
    access(1'b1, 32'h10, 32'hDEADBEEF);
    access(1'b0, 32'h10, 32'h0);
    repeat (3) @(negedge clk_i);
    check_eq("rdata_held", rdata_o, 32'hDEADBEEF);

    // Misaligned store dropped, location unchanged
    access(1'b1, 32'h13, 32'h12345678);
    access(1'b0, 32'h10, 32'h0);

    // Out-of-range and misaligned loads
    access(1'b0, 32'h1000, 32'h0);
    access(1'b0, 32'h12, 32'h0);

    // Top word of the array
    access(1'b1, 32'hFFC, 32'hA5A50001);
    access(1'b0, 32'hFFC, 32'h0);

    // Back-to-back loads with req held high
    push_expect(1'b0, 32'h10, 32'h0);
    push_expect(1'b0, 32'hFFC, 32'h0);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10;
    k = 0;
    c = 0;
    for (int i = 0; i < 40 && k < 2; i++) begin
      @(negedge clk_i);
      c++;
      if (ack_o) begin
        t_ack[k] = c;
        k++;
        if (k == 1) addr_i = 32'hFFC;
      end
    end
    req_i = 1'b0;
    check_eq("b2b_acks", k, 2);
    if (k == 2) check_eq("b2b_spacing", t_ack[1] - t_ack[0], LAT + 2);

    // Reset during the wait of a store: store discarded
    access(1'b1, 32'h20, 32'h11);
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h55;
    repeat (2) @(negedge clk_i);
    req_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check_eq("rst_wait_stall", {31'b0, stall_o}, 32'd0);
    check_eq("rst_wait_ack", {31'b0, ack_o}, 32'd0);
    check_eq("rst_wait_rdata", rdata_o, 32'd0);
    last_rdata = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (8) @(negedge clk_i);
    check_eq("rst_no_ack", {31'b0, prev_ack}, 32'd0);
    access(1'b0, 32'h20, 32'h0);

    repeat (4) @(negedge clk_i);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
